// File: rtl/exibe_sequencia_controle.sv
// rtl/exibe_sequencia_controle.sv - LED playback sequencer for the memory game
//
// Purpose: on a start request, walks the sequence memory from address 0 up to
// a latched limit. Each entry is shown on the LEDs for T_ACESO cycles and then
// blanked for T_APAGADO cycles. A one-cycle flag marks completion.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   iniciar      in   start request, sampled only while idle
//   cancelar     in   synchronous abort back to idle, no completion pulse
//   limite       in   last address to display, latched when a run starts
//   dado_memoria in   sequence memory word at endereco (combinational read)
//   endereco     out  registered sequence memory address
//   leds         out  LED drive
//   exibindo     out  high whenever not idle
//   fim_exibicao out  one-cycle completion pulse
//   db_estado    out  current state code for debug display
module exibe_sequencia_controle #(
   parameter int T_ACESO   = 1000,
   parameter int T_APAGADO = 500,
   parameter int TW        = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       cancelar,
   input  logic [3:0] limite,
   input  logic [3:0] dado_memoria,
   output logic [3:0] endereco,
   output logic [3:0] leds,
   output logic       exibindo,
   output logic       fim_exibicao,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      OCIOSO  = 4'd0,
      PREPARA = 4'd1,
      ACENDE  = 4'd2,
      APAGA   = 4'd3,
      AVANCA  = 4'd4,
      TERMINA = 4'd5
   } estado_t;

   // Last timer value of each phase; the phase ends on the edge that sees it.
   localparam logic [TW-1:0] ACESO_ULT   = TW'(T_ACESO - 1);
   localparam logic [TW-1:0] APAGADO_ULT = TW'(T_APAGADO - 1);

   estado_t       estado_q;
   logic [3:0]    endereco_q;
   logic [3:0]    limite_q;
   logic [TW-1:0] timer_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q   <= OCIOSO;
         endereco_q <= '0;
         timer_q    <= '0;
         limite_q   <= '0;
      end else if (cancelar && estado_q != OCIOSO) begin
         // Abort wins over every in-flight transition and skips TERMINA.
         estado_q   <= OCIOSO;
         endereco_q <= '0;
         timer_q    <= '0;
      end else begin
         case (estado_q)
            OCIOSO: begin
               endereco_q <= '0;
               timer_q    <= '0;
               if (iniciar && !cancelar) estado_q <= PREPARA;
            end
            PREPARA: begin
               endereco_q <= '0;
               timer_q    <= '0;
               limite_q   <= limite;
               estado_q   <= ACENDE;
            end
            ACENDE: begin
               if (timer_q == ACESO_ULT) begin
                  timer_q  <= '0;
                  estado_q <= APAGA;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            APAGA: begin
               if (timer_q == APAGADO_ULT) begin
                  timer_q  <= '0;
                  // Finishing at the limit keeps endereco from ever wrapping.
                  estado_q <= (endereco_q == limite_q) ? TERMINA : AVANCA;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            AVANCA: begin
               endereco_q <= endereco_q + 1'b1;
               timer_q    <= '0;
               estado_q   <= ACENDE;
            end
            TERMINA: begin
               // Clear the address so idle always presents address 0.
               endereco_q <= '0;
               timer_q    <= '0;
               estado_q   <= OCIOSO;
            end
            default: begin
               endereco_q <= '0;
               timer_q    <= '0;
               estado_q   <= OCIOSO;
            end
         endcase
      end
   end

   // Moore outputs decoded from the registered state.
   assign endereco     = endereco_q;
   assign leds         = (estado_q == ACENDE) ? dado_memoria : 4'd0;
   assign exibindo     = (estado_q != OCIOSO);
   assign fim_exibicao = (estado_q == TERMINA);
   assign db_estado    = estado_q;

endmodule
